// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect, MDU wait with timeout.
// Stall/flush outputs are combinational from state and inputs; stall_cnt counts stalled cycles.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken_ex,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             imem_ready,
  input  logic             perf_clr,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             stall_idex,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       state,
  output logic             mdu_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MDU_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MDU_TIMEOUT - 1);

  state_e     cur_q, nxt;
  logic [7:0] wcnt_q;
  logic       wcnt_clr, wcnt_inc, err_set;
  logic       lu;
  logic       sp, sif, fif, sidex, fidex, fexm;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    nxt      = cur_q;
    wcnt_clr = 1'b0;
    wcnt_inc = 1'b0;
    err_set  = 1'b0;
    sp       = 1'b0;
    sif      = 1'b0;
    fif      = 1'b0;
    sidex    = 1'b0;
    fidex    = 1'b0;
    fexm     = 1'b0;
    case (cur_q)
      REDIRECT: begin
        if (imem_ready) begin
          nxt = RUN;
        end else begin
          sp  = 1'b1;
          fif = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          nxt = RUN;
        end else begin
          sp    = 1'b1;
          sif   = 1'b1;
          sidex = 1'b1;
          fexm  = 1'b1;
          if (wcnt_q == WAIT_LAST) begin
            err_set = 1'b1;
            nxt     = RUN;
          end else begin
            wcnt_inc = 1'b1;
          end
        end
      end
      RUN, ILLEGAL: begin
        if (branch_taken_ex) begin
          fif   = 1'b1;
          fidex = 1'b1;
          nxt   = imem_ready ? RUN : REDIRECT;
        end else begin
          if (mdu_start && !mdu_done) begin
            sp       = 1'b1;
            sif      = 1'b1;
            sidex    = 1'b1;
            fexm     = 1'b1;
            wcnt_clr = 1'b1;
            nxt      = MDU_WAIT;
          end else if (lu) begin
            sp    = 1'b1;
            sif   = 1'b1;
            fidex = 1'b1;
          end
          // A held IF/ID keeps its instruction, so the fetch bubble only goes in when not holding
          if (!imem_ready) begin
            sp  = 1'b1;
            fif = !sif;
          end
        end
        if (cur_q == ILLEGAL) nxt = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  assign stall_pc    = sp    & ~rst;
  assign stall_ifid  = sif   & ~rst;
  assign flush_ifid  = fif   & ~rst;
  assign stall_idex  = sidex & ~rst;
  assign flush_idex  = fidex & ~rst;
  assign flush_exmem = fexm  & ~rst;
  assign state       = cur_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q           <= RUN;
      wcnt_q          <= 8'd0;
      mdu_timeout_err <= 1'b0;
      stall_cnt       <= '0;
    end else begin
      cur_q <= nxt;
      if (wcnt_clr)      wcnt_q <= 8'd0;
      else if (wcnt_inc) wcnt_q <= wcnt_q + 8'd1;
      if (err_set) mdu_timeout_err <= 1'b1;
      if (perf_clr)                     stall_cnt <= '0;
      else if (stall_pc && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized run against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic branch_taken_ex = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0;
  logic imem_ready = 1'b1, perf_clr = 1'b0;
  logic stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, flush_exmem;
  logic [1:0] state;
  logic mdu_timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model of the controller, expressed as spec rules
  int m_mode   = 0;   // 0 running, 1 awaiting redirect fetch, 2 waiting on MDU
  int m_waited = 0;   // cycles already spent waiting on MDU
  bit m_err    = 0;
  int m_cnt    = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken_ex(branch_taken_ex),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .imem_ready(imem_ready), .perf_clr(perf_clr),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .stall_idex(stall_idex), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .state(state), .mdu_timeout_err(mdu_timeout_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, flush_exmem}
  function automatic logic [5:0] outs();
    return {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, flush_exmem};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
    branch_taken_ex = 0; mdu_start = 0; mdu_done = 0; imem_ready = 1; perf_clr = 0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  function automatic logic [5:0] model_outs();
    bit hz, sp, sif, fif, sidex, fidex, fexm;
    hz = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {sp, sif, fif, sidex, fidex, fexm} = 6'b0;
    if (rst) return 6'b0;
    if (m_mode == 1) begin
      if (!imem_ready) begin sp = 1; fif = 1; end
    end else if (m_mode == 2) begin
      if (!mdu_done) begin sp = 1; sif = 1; sidex = 1; fexm = 1; end
    end else if (branch_taken_ex) begin
      fif = 1; fidex = 1;
    end else begin
      if (mdu_start && !mdu_done) begin sp = 1; sif = 1; sidex = 1; fexm = 1; end
      else if (hz) begin sp = 1; sif = 1; fidex = 1; end
      if (!imem_ready) begin sp = 1; if (!sif) fif = 1; end
    end
    return {sp, sif, fif, sidex, fidex, fexm};
  endfunction

  task automatic model_advance(input logic [5:0] e);
    if (rst) begin
      m_mode = 0; m_waited = 0; m_err = 0; m_cnt = 0;
      return;
    end
    if (perf_clr) m_cnt = 0;
    else if (e[5] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    case (m_mode)
      1: if (imem_ready) m_mode = 0;
      2: begin
        if (mdu_done) m_mode = 0;
        else begin
          m_waited++;
          if (m_waited == TMO) begin m_mode = 0; m_err = 1; end
        end
      end
      default: begin
        if (branch_taken_ex) m_mode = imem_ready ? 0 : 1;
        else if (mdu_start && !mdu_done) begin m_mode = 2; m_waited = 0; end
      end
    endcase
  endtask

  task automatic test_reset();
    set_lu(); imem_ready = 0; mdu_start = 1;
    #3;
    n_checks++;
    if (outs() !== 6'b0) begin n_fail++; $display("FAIL reset_outs got=%b want=000000", outs()); end
    n_checks++;
    if (state !== 2'd0 || mdu_timeout_err !== 1'b0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_regs got state=%0d err=%b cnt=%0d want 0/0/0", state, mdu_timeout_err, stall_cnt);
    end
    tick();
    idle();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (outs() !== 6'b0 || state !== 2'd0) begin n_fail++; $display("FAIL post_reset got=%b st=%0d want=000000 st=0", outs(), state); end
    tick();
  endtask

  task automatic test_load_use();
    idle(); perf_clr = 1; tick(); perf_clr = 0;
    set_lu();
    @(negedge clk);
    n_checks++;
    if (outs() !== 6'b110010) begin n_fail++; $display("FAIL lu_outs got=%b want=110010", outs()); end
    n_checks++;
    if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL lu_cnt0 got=%0d want=0", stall_cnt); end
    tick();
    n_checks++;
    if (stall_cnt !== 4'd1 || state !== 2'd0) begin n_fail++; $display("FAIL lu_cnt1 got cnt=%0d st=%0d want 1/0", stall_cnt, state); end
    ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    n_checks++;
    if (outs() !== 6'b0) begin n_fail++; $display("FAIL lu_rd0 got=%b want=000000", outs()); end
    tick(); idle();
  endtask

  task automatic test_branch();
    logic [5:0] want;
    for (int i = 0; i < 5; i++) begin
      idle();
      branch_taken_ex = (i == 0);
      imem_ready = (i >= 3);
      @(negedge clk);
      want = (i == 0) ? 6'b001010 : (i <= 2) ? 6'b101000 : 6'b000000;
      n_checks++;
      if (outs() !== want) begin n_fail++; $display("FAIL br_outs c%0d got=%b want=%b", i, outs(), want); end
      n_checks++;
      if (state !== ((i >= 1 && i <= 3) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL br_state c%0d got=%0d", i, state); end
      tick();
    end
    idle();
  endtask

  task automatic test_mdu();
    logic [5:0] want;
    idle(); perf_clr = 1; tick(); perf_clr = 0;
    for (int i = 0; i <= 6; i++) begin
      mdu_start = (i == 0);
      mdu_done  = (i == 5);
      @(negedge clk);
      want = (i <= 4) ? 6'b110101 : 6'b000000;
      n_checks++;
      if (outs() !== want) begin n_fail++; $display("FAIL mdu_outs c%0d got=%b want=%b", i, outs(), want); end
      n_checks++;
      if (state !== ((i >= 1 && i <= 5) ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL mdu_state c%0d got=%0d", i, state); end
      tick();
    end
    n_checks++;
    if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL mdu_cnt got=%0d want=5", stall_cnt); end
    idle();
  endtask

  task automatic test_priority();
    idle(); set_lu(); branch_taken_ex = 1; mdu_start = 1;
    @(negedge clk);
    n_checks++;
    if (outs() !== 6'b001010) begin n_fail++; $display("FAIL prio_all got=%b want=001010", outs()); end
    tick();
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL prio_state got=%0d want=0", state); end
    branch_taken_ex = 0; mdu_start = 0; imem_ready = 0;
    @(negedge clk);
    n_checks++;
    if (outs() !== 6'b110010) begin n_fail++; $display("FAIL prio_lu_imem got=%b want=110010", outs()); end
    tick(); idle();
  endtask

  task automatic test_saturate();
    idle(); perf_clr = 1; tick(); perf_clr = 0;
    imem_ready = 0;
    repeat (20) tick();
    n_checks++;
    if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got=%0d want=15", stall_cnt); end
    perf_clr = 1; tick(); perf_clr = 0;
    n_checks++;
    if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_prio got=%0d want=0", stall_cnt); end
    idle(); tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 12; i++) begin
      mdu_start = (i == 0);
      mdu_done  = 0;
      @(negedge clk);
      n_checks++;
      if (state !== ((i >= 1 && i <= TMO) ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL tmo_state c%0d got=%0d", i, state); end
      n_checks++;
      if (mdu_timeout_err !== (i >= TMO + 1)) begin n_fail++; $display("FAIL tmo_err c%0d got=%b", i, mdu_timeout_err); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    mdu_start = 1; tick(); mdu_start = 0; tick(); tick();
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL rmid_pre got=%0d want=2", state); end
    rst = 1;
    #1;
    n_checks++;
    if (outs() !== 6'b0 || state !== 2'd0) begin n_fail++; $display("FAIL rmid_async got=%b st=%0d want 000000/0", outs(), state); end
    tick();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (outs() !== 6'b0 || state !== 2'd0 || stall_cnt !== '0 || mdu_timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_rel got=%b st=%0d cnt=%0d err=%b want 000000/0/0/0", outs(), state, stall_cnt, mdu_timeout_err);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] e;
    idle(); rst = 1; tick(); rst = 0;
    m_mode = 0; m_waited = 0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      branch_taken_ex = ($urandom_range(0, 9) == 0);
      mdu_start  = ($urandom_range(0, 6) == 0);
      mdu_done   = ($urandom_range(0, 9) < 2);
      imem_ready = ($urandom_range(0, 3) != 0);
      perf_clr   = ($urandom_range(0, 40) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      if (rst) begin m_mode = 0; m_waited = 0; m_err = 0; m_cnt = 0; end
      @(negedge clk);
      e = model_outs();
      n_checks++;
      if (outs() !== e || state !== 2'(m_mode) || mdu_timeout_err !== m_err || stall_cnt !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand c%0d got outs=%b st=%0d err=%b cnt=%0d want outs=%b st=%0d err=%b cnt=%0d",
                 i, outs(), state, mdu_timeout_err, stall_cnt, e, m_mode, m_err, m_cnt);
      end
      model_advance(e);
      tick();
    end
    rst = 0; idle(); tick();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_priority();
    test_saturate();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall performance counter.
REQ-002 Parameter: MDU_TIMEOUT, 64, maximum number of cycles spent in MDU_WAIT before abort (legal range 2..255).
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Ports: id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 Ports: id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-007 Ports: ex_mem_read  in  1, ex_rd  in  5  EX instruction is a load, and its destination register.
REQ-008 Port: branch_taken_ex  in  1  taken branch or jump resolved in EX; the PC loads the target this cycle.
REQ-009 Ports: mdu_start, mdu_done  in  1 each  multi-cycle mul/div op present in EX, and its result valid.
REQ-010 Port: imem_ready  in  1  the fetch in IF returns a valid instruction this cycle.
REQ-011 Port: perf_clr  in  1  synchronous clear of stall_cnt.
REQ-012 Ports: stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, flush_exmem  out  1 each  hold/bubble controls to the PC and pipe registers.
REQ-013 Ports: state  out  2  current FSM state; mdu_timeout_err  out  1  sticky abort flag; stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-014 FSM states: RUN=0, REDIRECT=1, MDU_WAIT=2; encoding 3 SHALL behave as RUN and go to RUN next cycle.
REQ-015 Load-use hazard (lu): ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-016 RUN with branch_taken_ex=1 (highest priority): flush_ifid=1 and flush_idex=1, all other outputs 0; next state is REDIRECT unless imem_ready=1, in which case it is RUN.
REQ-017 RUN with mdu_start=1 and mdu_done=0 (no branch): stall_pc=stall_ifid=stall_idex=flush_exmem=1; next state MDU_WAIT; wait counter cleared to 0.
REQ-018 RUN with mdu_start=1 and mdu_done=1: no stall; state stays RUN.
REQ-019 RUN with lu=1 (no branch or MDU stall): stall_pc=stall_ifid=flush_idex=1 for that combinational cycle only; no state change.
REQ-020 RUN with imem_ready=0: stall_pc=1; flush_ifid=1 unless stall_ifid=1 (hold beats bubble; the two are never asserted together).
REQ-021 REDIRECT: stall_pc=1 and flush_ifid=1 while imem_ready=0; when imem_ready=1, all outputs are 0 and the next state is RUN.
REQ-022 MDU_WAIT with mdu_done=0: stall_pc=stall_ifid=stall_idex=flush_exmem=1; the wait counter increments.
REQ-023 MDU_WAIT with mdu_done=1: all outputs 0; next state RUN.
REQ-024 MDU_WAIT timeout: when the wait counter equals MDU_TIMEOUT-1 and mdu_done=0, the stalls are still asserted that cycle, mdu_timeout_err is set (sticky until reset), and the next state is RUN; total MDU_WAIT dwell is exactly MDU_TIMEOUT cycles.
REQ-025 branch_taken_ex in REDIRECT or MDU_WAIT is ignored.
REQ-026 Every output except state, mdu_timeout_err and stall_cnt is combinational from state and inputs, with no registered latency.
REQ-027 stall_cnt increments by 1 on each cycle with stall_pc=1 and saturates at all-ones.
REQ-028 perf_clr has priority over the stall_cnt increment; stall_cnt is 0 on the cycle after perf_clr.

Reset
REQ-029 While rst=1, all control outputs are forced to 0; state=RUN, the wait counter is 0, mdu_timeout_err=0 and stall_cnt=0.
REQ-030 Reset asserted mid-MDU_WAIT or mid-REDIRECT aborts immediately; the first cycle after release is RUN with no stall.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> stall_pc=stall_ifid=flush_idex=1 for 1 cycle; stall_cnt goes 0->1; same stimulus with ex_rd=0 -> no stall.
REQ-032 Branch: branch_taken_ex=1 with imem_ready=0 for the next 2 cycles -> cycle 0 flush_ifid=flush_idex=1; cycles 1-2 state=1, stall_pc=flush_ifid=1; cycle 3 with imem_ready=1 -> outputs 0 and state=0 next.
REQ-033 MDU: mdu_start at cycle 0, mdu_done at cycle 5 -> stalls asserted in cycles 0-4, state=2 in cycles 1-5, state=0 at cycle 6; stall_cnt=5.
REQ-034 Timeout: MDU_TIMEOUT=8, mdu_done held 0 -> exactly 8 cycles in state=2; mdu_timeout_err=1 from cycle 9 onward; state=0.
REQ-035 Priority: branch_taken_ex, mdu_start and lu all high in one RUN cycle -> only flush_ifid and flush_idex are asserted; imem_ready=0 with lu=1 -> flush_ifid=0.
REQ-036 Counter/reset: CNT_W=4 with 20 stalled cycles -> stall_cnt=15; rst pulsed in MDU_WAIT -> state=0, stall_cnt=0, err=0 after release.
